multiplicador_vectorial: RTL and testbench



---
 rtl/mult_pkg.sv | 26 ++
 rtl/multiplicador_vectorial_if.sv | 34 +++
 rtl/mult_lane.sv | 49 ++++
 rtl/multiplicador_vectorial.sv | 100 ++++++++++
 tb/tb_multiplicador_vectorial.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the lane-parallel vector multiplier:
//   - default geometry (N, LANES, STAGES, FRAC)
//   - lane operand typedef
//   - saturation bound helpers (largest / smallest signed value of n bits)
// Optional feature macro used by the design: MULT_SAT_EN (saturate mode).
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int N_DEF      = 19;
  localparam int LANES_DEF  = 4;
  localparam int STAGES_DEF = 2;
  localparam int FRAC_DEF   = 0;

  typedef logic signed [N_DEF-1:0] lane_t;

  function automatic longint sat_max(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/multiplicador_vectorial_if.sv
// ---------------------------------------------------------------------------
// multiplicador_vectorial_if
// Valid/ready beat bus of the vector multiplier.
//   in_valid/in_ready  : input beat handshake (a, b, sat_en travel with it)
//   out_valid/out_ready: result beat handshake (out, overflow travel with it)
// Lane i occupies bits [i*N +: N] of a, b and out.
// Modports: master = producer/consumer around the block, slave = the block.
// ---------------------------------------------------------------------------
interface multiplicador_vectorial_if
  import mult_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*N-1:0]   a;
  logic [LANES*N-1:0]   b;
  logic                 sat_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   out;
  logic [LANES-1:0]     overflow;

  modport master (
    output in_valid, a, b, sat_en, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, a, b, sat_en, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/mult_lane.sv
// ---------------------------------------------------------------------------
// mult_lane
// Combinational single-lane datapath: full 2N-bit signed product, arithmetic
// right shift by FRAC (floor rounding), range check against N-bit signed,
// optional saturation.
// Ports: a, b (N-bit signed operands), sat_en (saturate request),
//        res (N-bit result), ovf (shifted product out of N-bit range).
// Macro: MULT_SAT_EN builds the saturation path; without it results wrap.
// ---------------------------------------------------------------------------
module mult_lane
  import mult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sat_en,
  output logic [N-1:0] res,
  output logic         ovf
);
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;
  logic        [N:0]     top_bits;

  assign prod    = $signed(a) * $signed(b);
  assign shifted = prod >>> FRAC;

  // In range exactly when every bit from N-1 upward equals the sign bit.
  assign top_bits = shifted[2*N-1:N-1];
  assign ovf      = ~((&top_bits) | (~|top_bits));

`ifdef MULT_SAT_EN
  localparam logic [N-1:0] MAX_VAL = N'(sat_max(N));
  localparam logic [N-1:0] MIN_VAL = N'(sat_min(N));

  always_comb begin
    res = shifted[N-1:0];
    if (sat_en && ovf) begin
      res = shifted[2*N-1] ? MIN_VAL : MAX_VAL;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_en;
  assign res        = shifted[N-1:0];
`endif

endmodule

// File: rtl/multiplicador_vectorial.sv
// ---------------------------------------------------------------------------
// multiplicador_vectorial
// Pipelined LANES-wide signed multiplier with optional fixed-point shift and
// wrap/saturate result mode. Products are formed combinationally on the
// accepted beat and then carried through STAGES result registers, so the
// latency is STAGES cycles. A single global stall freezes every stage.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/a/b/sat_en, out_valid/out_ready/out/overflow
//   ovf_sticky  : OR of overflow bits of all delivered beats since clear
//   ovf_clr     : clears ovf_sticky (a same-cycle set takes priority)
// Macro: MULT_SAT_EN enables saturate mode (sat_en ignored otherwise).
// ---------------------------------------------------------------------------
module multiplicador_vectorial
  import mult_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multiplicador_vectorial_if.slave    bus,
  output logic                        ovf_sticky,
  input  logic                        ovf_clr
);
  genvar gi;

  logic [LANES*N-1:0] lane_res;
  logic [LANES-1:0]   lane_ovf;

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    mult_lane #(.N(N), .FRAC(FRAC)) u_lane (
      .a      (bus.a[gi*N +: N]),
      .b      (bus.b[gi*N +: N]),
      .sat_en (bus.sat_en),
      .res    (lane_res[gi*N +: N]),
      .ovf    (lane_ovf[gi])
    );
  end

  logic [STAGES-1:0]  vld_reg;
  logic [STAGES-1:0]  vld_next;
  logic [LANES*N-1:0] res_reg  [STAGES];
  logic [LANES*N-1:0] res_next [STAGES];
  logic [LANES-1:0]   ovf_reg  [STAGES];
  logic [LANES-1:0]   ovf_next [STAGES];
  logic               stall;
  logic               ovf_sticky_reg;

  // The output stage holding a beat nobody takes freezes the whole pipe.
  assign stall        = vld_reg[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign vld_next[gi] = bus.in_valid;
      assign res_next[gi] = lane_res;
      assign ovf_next[gi] = lane_ovf;
    end else begin : g_body
      assign vld_next[gi] = vld_reg[gi-1];
      assign res_next[gi] = res_reg[gi-1];
      assign ovf_next[gi] = ovf_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int s = 0; s < STAGES; s++) begin
        res_reg[s] <= '0;
        ovf_reg[s] <= '0;
      end
    end else if (!stall) begin
      vld_reg <= vld_next;
      for (int s = 0; s < STAGES; s++) begin
        res_reg[s] <= res_next[s];
        ovf_reg[s] <= ovf_next[s];
      end
    end
  end

  assign bus.out_valid = vld_reg[STAGES-1];
  assign bus.out       = res_reg[STAGES-1];
  assign bus.overflow  = ovf_reg[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_reg <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && (|bus.overflow)) begin
      ovf_sticky_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_multiplicador_vectorial.sv
// ---------------------------------------------------------------------------
// tb_multiplicador_vectorial
// Two instances share one stimulus stream: dut (FRAC=0) and dut8 (FRAC=8).
// Expected results come from a longint arithmetic model of the lane rules.
// Saturation expectations follow MULT_SAT_EN.
// ---------------------------------------------------------------------------
module tb_multiplicador_vectorial;
  import mult_pkg::*;

  localparam int N      = 19;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N - 1));
`ifdef MULT_SAT_EN
  localparam bit HAS_SAT = 1'b1;
`else
  localparam bit HAS_SAT = 1'b0;
`endif

  typedef logic [LANES*N-1:0] vec_t;
  typedef struct {
    vec_t             o0;
    vec_t             o8;
    logic [LANES-1:0] v0;
    logic [LANES-1:0] v8;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ovf_clr = 1'b0;
  logic sticky0;
  logic sticky8;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multiplicador_vectorial_if #(.N(N), .LANES(LANES)) bus ();
  multiplicador_vectorial_if #(.N(N), .LANES(LANES)) bus8 ();

  assign bus8.in_valid  = bus.in_valid;
  assign bus8.a         = bus.a;
  assign bus8.b         = bus.b;
  assign bus8.sat_en    = bus.sat_en;
  assign bus8.out_ready = bus.out_ready;

  multiplicador_vectorial #(.N(N), .LANES(LANES), .STAGES(STAGES), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_sticky(sticky0), .ovf_clr(ovf_clr)
  );
  multiplicador_vectorial #(.N(N), .LANES(LANES), .STAGES(STAGES), .FRAC(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .ovf_sticky(sticky8), .ovf_clr(ovf_clr)
  );

  // ---------------- reference model ----------------
  function automatic void ref_lane(input longint av, input longint bv, input int frac,
                                   input bit sat, output logic [N-1:0] r, output bit o);
    longint s;
    s = (av * bv) >>> frac;
    o = (s > MAXV) || (s < MINV);
    if (HAS_SAT && sat && o) s = (s > 0) ? MAXV : MINV;
    r = s[N-1:0];
  endfunction

  function automatic exp_t ref_beat(input vec_t av, input vec_t bv, input bit sat);
    exp_t e;
    logic [N-1:0] r;
    bit o;
    longint x, y;
    for (int i = 0; i < LANES; i++) begin
      x = longint'($signed(av[i*N +: N]));
      y = longint'($signed(bv[i*N +: N]));
      ref_lane(x, y, 0, sat, r, o);
      e.o0[i*N +: N] = r;
      e.v0[i] = o;
      ref_lane(x, y, 8, sat, r, o);
      e.o8[i*N +: N] = r;
      e.v8[i] = o;
    end
    return e;
  endfunction

  function automatic vec_t pack4(input int l0, input int l1, input int l2, input int l3);
    int t[4];
    logic [31:0] u;
    vec_t r;
    t[0] = l0; t[1] = l1; t[2] = l2; t[3] = l3;
    for (int i = 0; i < LANES; i++) begin
      u = t[i];
      r[i*N +: N] = u[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [31:0] u;
    int v;
    case ($urandom_range(0, 3))
      0: u = $urandom();
      1: begin v = int'($urandom_range(0, 2200)) - 1100; u = v; end
      2: begin
        case ($urandom_range(0, 3))
          0: u = 32'(MAXV);
          1: u = 32'(MINV);
          2: u = 32'hFFFF_FFFF;
          default: u = 32'd1;
        endcase
      end
      default: begin v = int'($urandom_range(0, 1200)) - 600; u = v; end
    endcase
    return u[N-1:0];
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i*N +: N] = rand_op();
    return r;
  endfunction

  // Drives one beat into an idle pipe and waits (bounded) for its result.
  task automatic run_beat(input vec_t av, input vec_t bv, input bit sat,
                          output vec_t o0, output logic [LANES-1:0] v0,
                          output vec_t o8, output logic [LANES-1:0] v8, output int lat);
    @(posedge clk); #1;
    bus.a = av; bus.b = bv; bus.sat_en = sat; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    o0 = bus.out; v0 = bus.overflow; o8 = bus8.out; v8 = bus8.overflow;
    $display("beat a=%h b=%h sat=%0d -> out=%h ovf=%b out8=%h lat=%0d", av, bv, sat, o0, v0, o8, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sat_en = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.out !== '0) begin n_bad++; $display("FAIL reset_out: got %h required 0", bus.out); end
    n_cmp++; if (bus.overflow !== '0) begin n_bad++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    n_cmp++; if (sticky0 !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b required 0", sticky0); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    vec_t o0, o8; logic [LANES-1:0] v0, v8; int lat;
    vec_t exp_o;
    exp_o = pack4(-60000, 0, 63, 262142);
    run_beat(pack4(300, 0, -7, 131071), pack4(-200, 5, -9, 2), 1'b0, o0, v0, o8, v8, lat);
    n_cmp++; if (o0 !== exp_o) begin n_bad++; $display("FAIL basic_out: got %h required %h", o0, exp_o); end
    n_cmp++; if (v0 !== 4'b0000) begin n_bad++; $display("FAIL basic_ovf: got %b required 0000", v0); end
    n_cmp++; if (lat !== STAGES) begin n_bad++; $display("FAIL basic_latency: got %0d required %0d", lat, STAGES); end
  endtask

  task automatic test_wrap_overflow();
    vec_t o0, o8; logic [LANES-1:0] v0, v8; int lat;
    vec_t av, bv, exp_o;
    av = pack4(1000, -1000, -262144, 262143);
    bv = pack4(1000, 1000, -1, 1);
    exp_o = pack4(-48576, 48576, -262144, 262143);
    run_beat(av, bv, 1'b0, o0, v0, o8, v8, lat);
    n_cmp++; if (o0 !== exp_o) begin n_bad++; $display("FAIL wrap_out: got %h required %h", o0, exp_o); end
    n_cmp++; if (v0 !== 4'b0111) begin n_bad++; $display("FAIL wrap_ovf: got %b required 0111", v0); end
    @(posedge clk); #1;
    n_cmp++; if (sticky0 !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b required 1", sticky0); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_cmp++; if (sticky0 !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b required 0", sticky0); end
    // clear raised in the same cycle as an overflowing delivery
    run_beat(av, bv, 1'b0, o0, v0, o8, v8, lat);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_cmp++; if (sticky0 !== 1'b1) begin n_bad++; $display("FAIL sticky_set_wins: got %b required 1", sticky0); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic test_saturate();
    vec_t o0, o8; logic [LANES-1:0] v0, v8; int lat;
    vec_t exp_o;
    exp_o = HAS_SAT ? pack4(262143, -262144, 262143, 262143)
                    : pack4(-48576, 48576, -262144, 262143);
    run_beat(pack4(1000, -1000, -262144, 262143), pack4(1000, 1000, -1, 1), 1'b1,
             o0, v0, o8, v8, lat);
    n_cmp++; if (o0 !== exp_o) begin n_bad++; $display("FAIL sat_out: got %h required %h", o0, exp_o); end
    n_cmp++; if (v0 !== 4'b0111) begin n_bad++; $display("FAIL sat_ovf: got %b required 0111", v0); end
    exp_o = pack4(-60000, 0, 63, 262142);
    run_beat(pack4(300, 0, -7, 131071), pack4(-200, 5, -9, 2), 1'b1, o0, v0, o8, v8, lat);
    n_cmp++; if (o0 !== exp_o) begin n_bad++; $display("FAIL sat_in_range: got %h required %h", o0, exp_o); end
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic test_frac();
    vec_t o0, o8; logic [LANES-1:0] v0, v8; int lat;
    vec_t exp8, exp0;
    exp8 = pack4(-384, -1, 0, 0);
    exp0 = pack4(-98304, -1, 128, 35);
    run_beat(pack4(256, -1, 128, 5), pack4(-384, 1, 1, 7), 1'b0, o0, v0, o8, v8, lat);
    n_cmp++; if (o8 !== exp8) begin n_bad++; $display("FAIL frac8_out: got %h required %h", o8, exp8); end
    n_cmp++; if (v8 !== 4'b0000) begin n_bad++; $display("FAIL frac8_ovf: got %b required 0000", v8); end
    n_cmp++; if (o0 !== exp0) begin n_bad++; $display("FAIL frac0_out: got %h required %h", o0, exp0); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int dlv = 0;
    bit holding = 0;
    vec_t held_o;
    logic [LANES-1:0] held_v;
    logic [5:0] sat_pat = 6'b101101;
    exp_t e;
    for (int cyc = 0; cyc < 60 && dlv < 6; cyc++) begin
      @(posedge clk); #1;
      bus.in_valid  = (acc < 6);
      bus.a         = pack4(1000 + 50*acc, -900 - 11*acc, 600 + acc, 12*acc);
      bus.b         = pack4(900, 1000, (acc % 2 == 0) ? 700 : -700, -3);
      bus.sat_en    = sat_pat[acc % 6];
      bus.out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 3) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_drop: got %b required 0", bus.in_ready); end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (holding) begin
          n_cmp++;
          if (bus.out !== held_o || bus.overflow !== held_v) begin
            n_bad++; $display("FAIL bp_hold: got %h/%b required %h/%b", bus.out, bus.overflow, held_o, held_v);
          end
        end
        held_o = bus.out; held_v = bus.overflow; holding = 1;
      end else begin
        holding = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(ref_beat(bus.a, bus.b, bus.sat_en));
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_beat: got delivery required none");
        end else begin
          e = sb.pop_front();
          if (bus.out !== e.o0 || bus.overflow !== e.v0 || bus8.out !== e.o8 || bus8.overflow !== e.v8) begin
            n_bad++; $display("FAIL bp_result: got %h/%b required %h/%b", bus.out, bus.overflow, e.o0, e.v0);
          end
        end
        $display("bp delivery %0d out=%h ovf=%b", dlv, bus.out, bus.overflow);
        dlv++;
      end
    end
    n_cmp++; if (acc != 6 || dlv != 6 || sb.size() != 0) begin
      n_bad++; $display("FAIL bp_count: got acc=%0d dlv=%0d left=%0d required 6/6/0", acc, dlv, sb.size());
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic test_random();
    bit sticky_m = 0;
    int dlv = 0;
    exp_t e;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      bus.in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      bus.a         = rand_vec();
      bus.b         = rand_vec();
      bus.sat_en    = $urandom_range(0, 1) == 1;
      bus.out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      ovf_clr       = $urandom_range(0, 9) == 0;
      @(negedge clk);
      n_cmp++; if (sticky0 !== sticky_m) begin n_bad++; $display("FAIL rnd_sticky cyc %0d: got %b required %b", cyc, sticky0, sticky_m); end
      if (bus.in_valid && bus.in_ready) sb.push_back(ref_beat(bus.a, bus.b, bus.sat_en));
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra_beat cyc %0d: got delivery required none", cyc);
        end else begin
          e = sb.pop_front();
          if (bus.out !== e.o0 || bus.overflow !== e.v0 || bus8.out !== e.o8 || bus8.overflow !== e.v8) begin
            n_bad++; $display("FAIL rnd_result cyc %0d: got %h/%b %h/%b required %h/%b %h/%b", cyc,
                              bus.out, bus.overflow, bus8.out, bus8.overflow, e.o0, e.v0, e.o8, e.v8);
          end
          if (|e.v0) sticky_m = 1'b1;
          else if (ovf_clr) sticky_m = 1'b0;
        end
        $display("rnd delivery %0d out=%h ovf=%b", dlv, bus.out, bus.overflow);
        dlv++;
      end else if (ovf_clr) begin
        sticky_m = 1'b0;
      end
    end
    ovf_clr = 1'b0;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d pending required 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    vec_t o0, o8; logic [LANES-1:0] v0, v8; int lat;
    int stale = 0;
    vec_t exp_o;
    run_beat(pack4(1000, 1, 1, 1), pack4(1000, 1, 1, 1), 1'b0, o0, v0, o8, v8, lat);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.a = pack4(11, 12, 13, 14); bus.b = pack4(2, 2, 2, 2);
    @(posedge clk); #1;
    bus.a = pack4(21, 22, 23, 24);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (sticky0 !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_state: got sticky=%b valid=%b required 1/1", sticky0, bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (sticky0 !== 1'b0) begin n_bad++; $display("FAIL async_reset_sticky: got %b required 0", sticky0); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL stale_beat: got %0d cycles valid required 0", stale); end
    exp_o = pack4(-60000, 0, 63, 262142);
    run_beat(pack4(300, 0, -7, 131071), pack4(-200, 5, -9, 2), 1'b0, o0, v0, o8, v8, lat);
    n_cmp++; if (lat !== STAGES) begin n_bad++; $display("FAIL post_reset_latency: got %0d required %0d", lat, STAGES); end
    n_cmp++; if (o0 !== exp_o) begin n_bad++; $display("FAIL post_reset_out: got %h required %h", o0, exp_o); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap_overflow();
    test_saturate();
    test_frac();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
